// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch resolution / gshare predictor.
//   ctr_e          : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   PHT_IDX_W_DEF  : default PHT index width (also the GHR width)
//   ctr_next()     : saturating counter next-state for a resolved outcome
package bp_pkg;

    localparam int PHT_IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturates at ST on taken and at SNT on not-taken; never wraps.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pht_array.sv
// pht_array -- pattern history table of 2-bit saturating counters.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   rd_idx_i     : combinational read index
//   rd_ctr_o     : counter at rd_idx_i (pre-update value in a write cycle)
//   wr_en_i      : train the entry at wr_idx_i on this rising edge
//   wr_idx_i     : training index
//   wr_taken_i   : resolved outcome used for training
// Training is a read-modify-write on the write index, so the array needs
// only one external read port (used by the fetch-side lookup).
module pht_array
    import bp_pkg::*;
#(
    parameter int         IDX_W    = PHT_IDX_W_DEF,
    parameter logic [1:0] CTR_INIT = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctr_q [DEPTH];

    // No bypass: a same-cycle write to rd_idx_i shows up on the next cycle.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_resolve_pht.sv
// branch_resolve_pht -- execute-stage branch resolution with gshare training.
// Ports:
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   F_PC_cur              : fetch PC for predictor lookup
//   F_predict, F_addr_PHT : predicted-taken bit and PHT index for fetch
//   E_branch, E_jump      : conditional branch / JAL-JALR in EX (jump wins)
//   E_predict, E_addr_PHT : prediction and index carried down the pipe
//   E_taken               : actual branch condition
//   E_target, E_PC_cur    : computed target and PC of the EX instruction
//   E_stall               : EX held, nothing resolves or trains
//   X_flush, X_redirect_pc: flush IF/ID + ID/EX and the PC to restart from
//   perf_branch_cnt, perf_mispredict_cnt : only with BP_PERF_CNT_EN defined
// Optional feature macro: BP_PERF_CNT_EN (saturating perf counters).
module branch_resolve_pht
    import bp_pkg::*;
#(
    parameter int         PHT_IDX_W = PHT_IDX_W_DEF,
    parameter logic [1:0] CTR_INIT  = WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          F_PC_cur,
    output logic                 F_predict,
    output logic [PHT_IDX_W-1:0] F_addr_PHT,
    input  logic                 E_branch,
    input  logic                 E_jump,
    input  logic                 E_predict,
    input  logic [PHT_IDX_W-1:0] E_addr_PHT,
    input  logic                 E_taken,
    input  logic [31:0]          E_target,
    input  logic [31:0]          E_PC_cur,
    input  logic                 E_stall,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]          perf_branch_cnt,
    output logic [31:0]          perf_mispredict_cnt,
`endif
    output logic                 X_flush,
    output logic [31:0]          X_redirect_pc
);

    logic [PHT_IDX_W-1:0] ghr_q, ghr_d;
    logic [1:0]           rd_ctr;
    logic [31:0]          pc_plus4;
    logic                 resolve_en;
    logic                 branch_res;
    logic                 mispredict;

    // Word-aligned PC bits only; the byte offset and upper PC bits do not
    // participate in the index.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_PC_cur[31:PHT_IDX_W+2], F_PC_cur[1:0]};

    // ---------------- lookup ----------------
    assign F_addr_PHT = F_PC_cur[PHT_IDX_W+1:2] ^ ghr_q;
    assign F_predict  = rd_ctr[1];

    // ---------------- resolve ----------------
    assign pc_plus4   = E_PC_cur + 32'd4;
    assign resolve_en = ~rst & ~E_stall;
    assign branch_res = resolve_en & E_branch & ~E_jump;
    assign mispredict = E_taken ^ E_predict;

    always_comb begin
        X_flush       = 1'b0;
        X_redirect_pc = pc_plus4;
        if (E_jump) begin
            X_flush       = resolve_en;
            X_redirect_pc = E_target;
        end else if (E_branch) begin
            X_flush       = resolve_en & mispredict;
            X_redirect_pc = E_taken ? E_target : pc_plus4;
        end
    end

    // ---------------- training ----------------
    pht_array #(
        .IDX_W    (PHT_IDX_W),
        .CTR_INIT (CTR_INIT)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (F_addr_PHT),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (branch_res),
        .wr_idx_i   (E_addr_PHT),
        .wr_taken_i (E_taken)
    );

    always_comb begin
        ghr_d = ghr_q;
        if (branch_res) begin
            ghr_d = {ghr_q[PHT_IDX_W-2:0], E_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (branch_res && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (branch_res && mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign perf_branch_cnt     = br_cnt_q;
    assign perf_mispredict_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_pht.sv
// Self-checking bench for branch_resolve_pht: directed literal checks that
// pin the reference model, then randomized traffic compared every cycle
// against a behavioural model (integer counters, shift history).
module tb_branch_resolve_pht;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   F_PC_cur;
    logic          F_predict;
    logic [W-1:0]  F_addr_PHT;
    logic          E_branch, E_jump, E_predict, E_taken, E_stall;
    logic [W-1:0]  E_addr_PHT;
    logic [31:0]   E_target, E_PC_cur;
    logic          X_flush;
    logic [31:0]   X_redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0]   perf_branch_cnt, perf_mispredict_cnt;
`endif

    int total = 0;
    int bad   = 0;

    branch_resolve_pht dut (
        .clk                 (clk),
        .rst                 (rst),
        .F_PC_cur            (F_PC_cur),
        .F_predict           (F_predict),
        .F_addr_PHT          (F_addr_PHT),
        .E_branch            (E_branch),
        .E_jump              (E_jump),
        .E_predict           (E_predict),
        .E_addr_PHT          (E_addr_PHT),
        .E_taken             (E_taken),
        .E_target            (E_target),
        .E_PC_cur            (E_PC_cur),
        .E_stall             (E_stall),
`ifdef BP_PERF_CNT_EN
        .perf_branch_cnt     (perf_branch_cnt),
        .perf_mispredict_cnt (perf_mispredict_cnt),
`endif
        .X_flush             (X_flush),
        .X_redirect_pc       (X_redirect_pc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_pht [1 << W];
    logic [W-1:0] m_ghr;
    longint      m_br, m_mis;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << W); i++) m_pht[i] = 1;
            m_ghr = '0;
            m_br  = 0;
            m_mis = 0;
        end else if (E_branch && !E_jump && !E_stall) begin
            if (E_taken) m_pht[E_addr_PHT] = (m_pht[E_addr_PHT] == 3) ? 3 : m_pht[E_addr_PHT] + 1;
            else         m_pht[E_addr_PHT] = (m_pht[E_addr_PHT] == 0) ? 0 : m_pht[E_addr_PHT] - 1;
            m_ghr = {m_ghr[W-2:0], E_taken};
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (E_taken != E_predict && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e_addr;
        logic         e_flush;
        logic [31:0]  e_redir;
        e_addr  = F_PC_cur[W+1:2] ^ m_ghr;
        e_flush = !rst && !E_stall && (E_jump || (E_branch && (E_taken != E_predict)));
        if (E_jump)                  e_redir = E_target;
        else if (E_branch && E_taken) e_redir = E_target;
        else                          e_redir = E_PC_cur + 32'd4;
        chk("cmp_addr", {24'd0, F_addr_PHT}, {24'd0, e_addr});
        chk("cmp_predict", {31'd0, F_predict}, {31'd0, m_pht[e_addr] >= 2});
        chk("cmp_flush", {31'd0, X_flush}, {31'd0, e_flush});
        if (!rst && !E_stall) chk("cmp_redirect", X_redirect_pc, e_redir);
`ifdef BP_PERF_CNT_EN
        chk("cmp_perf_br", perf_branch_cnt, m_br[31:0]);
        chk("cmp_perf_mis", perf_mispredict_cnt, m_mis[31:0]);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        E_branch = 0; E_jump = 0; E_predict = 0; E_taken = 0; E_stall = 0;
        E_addr_PHT = '0; E_target = '0; E_PC_cur = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [W-1:0] idx, input logic pred, input logic tk);
        E_branch = 1; E_jump = 0; E_stall = 0;
        E_addr_PHT = idx; E_predict = pred; E_taken = tk;
        E_PC_cur = 32'h400; E_target = 32'h800;
    endtask

    initial begin
        logic [7:0] lkp;
        rst = 1;
        F_PC_cur = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // reset lookup
        F_PC_cur = 32'h0000_0040;
        @(negedge clk);
        chk("rst_addr", {24'd0, F_addr_PHT}, 32'h10);
        chk("rst_predict", {31'd0, F_predict}, 32'd0);
        chk("rst_flush", {31'd0, X_flush}, 32'd0);
        next_cycle();

        // taken mispredict
        E_branch = 1; E_predict = 0; E_taken = 1; E_addr_PHT = 8'h40;
        E_PC_cur = 32'h100; E_target = 32'h180;
        @(negedge clk);
        chk("br1_flush", {31'd0, X_flush}, 32'd1);
        chk("br1_redirect", X_redirect_pc, 32'h180);
        next_cycle();
        idle();
        F_PC_cur = 32'h104;               // 0x41 ^ GHR(0x01) -> 0x40
        @(negedge clk);
        chk("br1_ghr", {24'd0, F_addr_PHT}, 32'h40);
        chk("br1_ctr", {31'd0, F_predict}, 32'd1);
        next_cycle();

        // not-taken mispredict
        E_branch = 1; E_predict = 1; E_taken = 0; E_addr_PHT = 8'h20;
        E_PC_cur = 32'h200; E_target = 32'h280;
        @(negedge clk);
        chk("br2_flush", {31'd0, X_flush}, 32'd1);
        chk("br2_redirect", X_redirect_pc, 32'h204);
        next_cycle();

        // saturation high: GHR 02 -> 05 0B 17 2F, counter 01 -> 11
        for (int i = 0; i < 4; i++) begin
            branch(8'h55, 1'b1, 1'b1);
            next_cycle();
        end
        idle();
        lkp = 8'h55 ^ 8'h2F;
        F_PC_cur = {22'd0, lkp, 2'b00};
        @(negedge clk);
        chk("sat_hi_addr", {24'd0, F_addr_PHT}, 32'h55);
        chk("sat_hi_pred", {31'd0, F_predict}, 32'd1);
        next_cycle();

        // saturation low: GHR -> 5E BC 78 F0, counter 11 -> 00
        for (int i = 0; i < 4; i++) begin
            branch(8'h55, 1'b0, 1'b0);
            next_cycle();
        end
        idle();
        lkp = 8'h55 ^ 8'hF0;
        F_PC_cur = {22'd0, lkp, 2'b00};
        @(negedge clk);
        chk("sat_lo_addr", {24'd0, F_addr_PHT}, 32'h55);
        chk("sat_lo_pred", {31'd0, F_predict}, 32'd0);
        next_cycle();

        // jump, then stalled jump and stalled branch: no training
        E_jump = 1; E_target = 32'h300; E_PC_cur = 32'h120;
        @(negedge clk);
        chk("jmp_flush", {31'd0, X_flush}, 32'd1);
        chk("jmp_redirect", X_redirect_pc, 32'h300);
        next_cycle();
        E_stall = 1;
        @(negedge clk);
        chk("jmp_stall_flush", {31'd0, X_flush}, 32'd0);
        next_cycle();
        branch(8'h55, 1'b0, 1'b1);
        E_stall = 1;
        next_cycle();
        idle();
        F_PC_cur = 32'h0;
        @(negedge clk);
        chk("jmp_ghr_kept", {24'd0, F_addr_PHT}, 32'hF0);
`ifdef BP_PERF_CNT_EN
        chk("perf_br_dir", perf_branch_cnt, 32'd10);
        chk("perf_mis_dir", perf_mispredict_cnt, 32'd2);
`endif
        next_cycle();

        // randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            E_branch = (r <= 5) || (r == 7);
            E_jump   = (r == 6) || (r == 7);
            E_stall  = ($urandom_range(0, 7) == 0);
            E_taken  = $urandom_range(0, 1);
            E_addr_PHT = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
            E_predict  = ($urandom_range(0, 2) == 0) ? 1'($urandom) : (m_pht[E_addr_PHT] >= 2);
            E_target = $urandom;
            E_PC_cur = (i % 97 == 0) ? 32'hFFFF_FFFC : $urandom;
            F_PC_cur = $urandom;
            if ($urandom_range(0, 3) == 0) F_PC_cur[W+1:2] = E_addr_PHT ^ m_ghr;
            @(negedge clk);
            if (i == 2000) begin
                #2 rst = 1;
                E_jump = 1;
                #1;
                chk("mid_rst_addr", {24'd0, F_addr_PHT}, {24'd0, F_PC_cur[W+1:2]});
                chk("mid_rst_pred", {31'd0, F_predict}, 32'd0);
                chk("mid_rst_flush", {31'd0, X_flush}, 32'd0);
`ifdef BP_PERF_CNT_EN
                chk("mid_rst_perf_br", perf_branch_cnt, 32'd0);
                chk("mid_rst_perf_mis", perf_mispredict_cnt, 32'd0);
`endif
                @(negedge clk);
                #2 rst = 0;
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
